// File: rtl/nbbpu_sequencer.sv
// NBBPU instruction-cycle sequencer: owns the FSM, ROM/RAM ready handshakes, timeout, halt and retire count.
// Optional single-step control is compiled in with `define SINGLE_STEP_EN (adds the step port).
module nbbpu_sequencer #(
    parameter int unsigned WAIT_LIMIT   = 16,
    parameter int unsigned RETIRE_WIDTH = 16,
    parameter bit          HALT_ON_RES  = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
`ifdef SINGLE_STEP_EN
    input  logic                    step,
`endif
    input  logic [3:0]              opcode,
    input  logic                    rom_ready,
    input  logic                    ram_ready,
    output logic                    instruction_enable,
    output logic                    read_enable,
    output logic                    reg_write,
    output logic                    reg_set,
    output logic                    write_enable,
    output logic                    jump_PC,
    output logic                    branch_PC,
    output logic [2:0]              state,
    output logic                    halted,
    output logic                    fault,
    output logic [RETIRE_WIDTH-1:0] retired
);

    localparam logic [3:0] OP_JMP = 4'd8;
    localparam logic [3:0] OP_BRZ = 4'd9;
    localparam logic [3:0] OP_BRN = 4'd10;
    localparam logic [3:0] OP_RES = 4'd11;
    localparam logic [3:0] OP_LOD = 4'd12;
    localparam logic [3:0] OP_STR = 4'd13;
    localparam logic [3:0] OP_SEL = 4'd14;
    localparam logic [3:0] OP_SEU = 4'd15;

    // Counter only needs to hold WAIT_LIMIT-1: the edge that would reach WAIT_LIMIT goes to FAULT.
    localparam int unsigned    WCW     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WCW-1:0] WC_LAST = (WAIT_LIMIT == 0) ? '0 : WCW'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMWAIT = 3'd4,
        S_STORE   = 3'd5,
        S_HALT    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    state_t         state_q;
    logic [3:0]     opcode_q;
    logic [WCW-1:0] wait_count;
    logic           timeout;
    logic           is_alu, is_jmp, is_br, is_lod, is_str, is_set, is_mem;

    assign state   = state_q;
    assign timeout = (WAIT_LIMIT != 0) && (wait_count == WC_LAST);

    assign is_alu = ~opcode_q[3];
    assign is_jmp = (opcode_q == OP_JMP);
    assign is_br  = (opcode_q == OP_BRZ) || (opcode_q == OP_BRN);
    assign is_lod = (opcode_q == OP_LOD);
    assign is_str = (opcode_q == OP_STR);
    assign is_set = (opcode_q == OP_SEL) || (opcode_q == OP_SEU);
    assign is_mem = is_lod || is_str;

`ifdef SINGLE_STEP_EN
    logic step_q;
    logic step_mode;
    logic step_rise;

    assign step_rise = step & ~step_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            wait_count <= '0;
            retired    <= '0;
            halted     <= 1'b0;
            fault      <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_q     <= 1'b0;
            step_mode  <= 1'b0;
`endif
        end else begin
`ifdef SINGLE_STEP_EN
            step_q <= step;
`endif
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_q <= S_FETCH;
                    end
`ifdef SINGLE_STEP_EN
                    else if (step_rise) begin
                        state_q   <= S_FETCH;
                        step_mode <= 1'b1;
                    end
`endif
                end
                S_FETCH: begin
                    if (rom_ready) begin
                        opcode_q   <= opcode;
                        wait_count <= '0;
                        state_q    <= S_DECODE;
                    end else if (timeout) begin
                        state_q <= S_FAULT;
                        fault   <= 1'b1;
                    end else if (WAIT_LIMIT != 0) begin
                        wait_count <= wait_count + WCW'(1);
                    end
                end
                S_DECODE: begin
                    if (HALT_ON_RES && (opcode_q == OP_RES)) begin
                        state_q <= S_HALT;
                        halted  <= 1'b1;
                    end else begin
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    state_q <= (is_mem && !ram_ready) ? S_MEMWAIT : S_STORE;
                end
                S_MEMWAIT: begin
                    if (ram_ready) begin
                        wait_count <= '0;
                        state_q    <= S_STORE;
                    end else if (timeout) begin
                        state_q <= S_FAULT;
                        fault   <= 1'b1;
                    end else if (WAIT_LIMIT != 0) begin
                        wait_count <= wait_count + WCW'(1);
                    end
                end
                S_STORE: begin
                    retired <= retired + RETIRE_WIDTH'(1);
`ifdef SINGLE_STEP_EN
                    if (step_mode) begin
                        step_mode <= 1'b0;
                        state_q   <= S_IDLE;
                    end else
`endif
                    state_q <= enable ? S_FETCH : S_IDLE;
                end
                S_HALT: begin
`ifdef SINGLE_STEP_EN
                    if (step_rise) begin
                        state_q   <= S_FETCH;
                        halted    <= 1'b0;
                        step_mode <= 1'b1;
                    end
`endif
                end
                default: state_q <= S_FAULT;
            endcase
        end
    end

    // Strobes depend only on the latched opcode so the ROM bus may change after FETCH.
    always_comb begin
        instruction_enable = 1'b0;
        read_enable        = 1'b0;
        reg_write          = 1'b0;
        reg_set            = 1'b0;
        write_enable       = 1'b0;
        jump_PC            = 1'b0;
        branch_PC          = 1'b0;
        case (state_q)
            S_FETCH: instruction_enable = 1'b1;
            S_DECODE: begin
                jump_PC   = is_jmp;
                branch_PC = is_br;
            end
            S_EXECUTE, S_MEMWAIT: begin
                jump_PC      = is_jmp;
                branch_PC    = is_br;
                read_enable  = is_lod;
                write_enable = is_str;
                reg_set      = is_set;
            end
            S_STORE: begin
                jump_PC      = is_jmp;
                branch_PC    = is_br;
                read_enable  = is_lod;
                write_enable = is_str;
                reg_set      = is_set;
                reg_write    = is_alu || is_jmp || is_lod || is_set;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nbbpu_sequencer.sv
// Self-checking bench for nbbpu_sequencer: two parameterisations driven in lockstep against a cycle-trace model.
module tb_nbbpu_sequencer;

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXECUTE = 3;
    localparam int ST_MEMWAIT = 4, ST_STORE = 5, ST_HALT = 6, ST_FAULT = 7;

    localparam logic [3:0] OP_ADD = 4'd0, OP_JMP = 4'd8, OP_BRZ = 4'd9, OP_BRN = 4'd10;
    localparam logic [3:0] OP_RES = 4'd11, OP_LOD = 4'd12, OP_STR = 4'd13;
    localparam logic [3:0] OP_SEL = 4'd14, OP_SEU = 4'd15;

    logic clock = 1'b0;
    logic reset, enable, rom_ready, ram_ready;
    logic [3:0] opcode;
`ifdef SINGLE_STEP_EN
    logic step = 1'b0;
`endif

    logic ie0, re0, rw0, rs0, we0, j0, b0, halted0, fault0;
    logic ie1, re1, rw1, rs1, we1, j1, b1, halted1, fault1;
    logic [2:0]  state0, state1;
    logic [3:0]  retired0;
    logic [15:0] retired1;
    logic [6:0]  c0, c1;

    int total = 0;
    int bad   = 0;

    assign c0 = {ie0, re0, rw0, rs0, we0, j0, b0};
    assign c1 = {ie1, re1, rw1, rs1, we1, j1, b1};

    always #5 clock = ~clock;

    nbbpu_sequencer #(.WAIT_LIMIT(4), .RETIRE_WIDTH(4), .HALT_ON_RES(1'b1)) dut0 (
        .clock(clock), .reset(reset), .enable(enable),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .rom_ready(rom_ready), .ram_ready(ram_ready),
        .instruction_enable(ie0), .read_enable(re0), .reg_write(rw0), .reg_set(rs0),
        .write_enable(we0), .jump_PC(j0), .branch_PC(b0), .state(state0),
        .halted(halted0), .fault(fault0), .retired(retired0)
    );

    nbbpu_sequencer #(.WAIT_LIMIT(16), .RETIRE_WIDTH(16), .HALT_ON_RES(1'b0)) dut1 (
        .clock(clock), .reset(reset), .enable(enable),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .opcode(opcode), .rom_ready(rom_ready), .ram_ready(ram_ready),
        .instruction_enable(ie1), .read_enable(re1), .reg_write(rw1), .reg_set(rs1),
        .write_enable(we1), .jump_PC(j1), .branch_PC(b1), .state(state1),
        .halted(halted1), .fault(fault1), .retired(retired1)
    );

    // Expected strobes {ie, re, rw, rs, we, jump, branch} for an instruction in a given phase.
    function automatic logic [6:0] exp_ctrl(int st, logic [3:0] op);
        logic [6:0] r;
        bit pc_phase, data_phase;
        r          = '0;
        pc_phase   = (st == ST_DECODE) || (st == ST_EXECUTE) || (st == ST_MEMWAIT) || (st == ST_STORE);
        data_phase = (st == ST_EXECUTE) || (st == ST_MEMWAIT) || (st == ST_STORE);
        if (st == ST_FETCH) r[6] = 1'b1;
        if (pc_phase && op == OP_JMP) r[1] = 1'b1;
        if (pc_phase && (op == OP_BRZ || op == OP_BRN)) r[0] = 1'b1;
        if (data_phase && op == OP_LOD) r[5] = 1'b1;
        if (data_phase && op == OP_STR) r[2] = 1'b1;
        if (data_phase && (op == OP_SEL || op == OP_SEU)) r[3] = 1'b1;
        if (st == ST_STORE && (op < 4'd8 || op == OP_JMP || op == OP_LOD || op == OP_SEL || op == OP_SEU))
            r[4] = 1'b1;
        return r;
    endfunction

    typedef struct {
        int         st;
        logic [6:0] ctrl;
        bit         rom;
        bit         ram;
        logic [3:0] op;
        bit         en;
    } cyc_t;

    task automatic do_reset;
        reset     = 1'b0;
        enable    = 1'b0;
        rom_ready = 1'b0;
        ram_ready = 1'b0;
        opcode    = 4'd0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; enable = 1'b1; rom_ready = 1'b1; ram_ready = 1'b1; opcode = OP_JMP;
        repeat (2) @(negedge clock);
        total++; if (state0 !== 3'd0) begin bad++; $display("FAIL reset_state0 got=%0d exp=0", state0); end
        total++; if (state1 !== 3'd0) begin bad++; $display("FAIL reset_state1 got=%0d exp=0", state1); end
        total++; if (c0 !== 7'd0) begin bad++; $display("FAIL reset_ctrl0 got=%b exp=0000000", c0); end
        total++; if ({halted0, fault0, halted1, fault1} !== 4'd0)
            begin bad++; $display("FAIL reset_flags got=%b exp=0000", {halted0, fault0, halted1, fault1}); end
        total++; if (retired0 !== 4'd0 || retired1 !== 16'd0)
            begin bad++; $display("FAIL reset_retired got=%0d/%0d exp=0/0", retired0, retired1); end
    endtask

    task automatic test_add;
        int seq[6] = '{0, 1, 2, 3, 5, 1};
        do_reset();
        opcode = OP_ADD; rom_ready = 1'b1; ram_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            total++; if (state0 !== 3'(seq[i])) begin bad++; $display("FAIL add_state i=%0d got=%0d exp=%0d", i, state0, seq[i]); end
            total++; if (rw0 !== (seq[i] == ST_STORE)) begin bad++; $display("FAIL add_reg_write i=%0d got=%b exp=%b", i, rw0, seq[i] == ST_STORE); end
            total++; if (retired0 !== 4'((i == 5) ? 1 : 0)) begin bad++; $display("FAIL add_retired i=%0d got=%0d exp=%0d", i, retired0, (i == 5) ? 1 : 0); end
            enable = 1'b1;
        end
    endtask

    task automatic test_lod_wait;
        int seq[9] = '{0, 1, 2, 3, 4, 4, 4, 5, 1};
        do_reset();
        opcode = OP_LOD; rom_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            total++; if (state0 !== 3'(seq[i])) begin bad++; $display("FAIL lod_state i=%0d got=%0d exp=%0d", i, state0, seq[i]); end
            total++; if (c0 !== exp_ctrl(seq[i], OP_LOD)) begin bad++; $display("FAIL lod_ctrl i=%0d got=%b exp=%b", i, c0, exp_ctrl(seq[i], OP_LOD)); end
            enable    = 1'b1;
            ram_ready = (i >= 6);
        end
    endtask

    task automatic test_timeout;
        int seq1[7]  = '{0, 1, 1, 1, 1, 7, 7};
        int seq2[12] = '{0, 1, 1, 1, 1, 2, 3, 4, 4, 4, 4, 7};
        do_reset();
        opcode = OP_ADD;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            total++; if (state0 !== 3'(seq1[i])) begin bad++; $display("FAIL fetch_to_state i=%0d got=%0d exp=%0d", i, state0, seq1[i]); end
            total++; if (fault0 !== (seq1[i] == ST_FAULT)) begin bad++; $display("FAIL fetch_to_fault i=%0d got=%b exp=%b", i, fault0, seq1[i] == ST_FAULT); end
            enable = 1'b1;
        end
        total++; if (state1 !== 3'd1) begin bad++; $display("FAIL fetch_to_long_limit got=%0d exp=1", state1); end
        rom_ready = 1'b1; ram_ready = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (state0 !== 3'd7 || c0 !== 7'd0) begin bad++; $display("FAIL fault_sticky state=%0d ctrl=%b exp=7/0000000", state0, c0); end
        #1 reset = 1'b0;
        #1;
        total++; if (state0 !== 3'd0 || fault0 !== 1'b0) begin bad++; $display("FAIL async_reset state=%0d fault=%b exp=0/0", state0, fault0); end
        enable = 1'b0; rom_ready = 1'b0; ram_ready = 1'b0; opcode = OP_LOD;
        @(negedge clock) reset = 1'b1;
        // Ready on the last allowed FETCH cycle wins; then the MEMWAIT timeout trips.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            total++; if (state0 !== 3'(seq2[i])) begin bad++; $display("FAIL edge_to_state i=%0d got=%0d exp=%0d", i, state0, seq2[i]); end
            total++; if (fault0 !== (seq2[i] == ST_FAULT)) begin bad++; $display("FAIL edge_to_fault i=%0d got=%b exp=%b", i, fault0, seq2[i] == ST_FAULT); end
            enable    = 1'b1;
            rom_ready = (i == 4);
        end
    endtask

    task automatic test_res;
        int s0[6] = '{0, 1, 2, 6, 6, 6};
        int s1[6] = '{0, 1, 2, 3, 5, 0};
        do_reset();
        opcode = OP_RES; rom_ready = 1'b1; ram_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            total++; if (state0 !== 3'(s0[i])) begin bad++; $display("FAIL res_halt_state i=%0d got=%0d exp=%0d", i, state0, s0[i]); end
            total++; if (halted0 !== (s0[i] == ST_HALT)) begin bad++; $display("FAIL res_halted i=%0d got=%b exp=%b", i, halted0, s0[i] == ST_HALT); end
            total++; if (c0 !== exp_ctrl(s0[i], OP_RES)) begin bad++; $display("FAIL res_halt_ctrl i=%0d got=%b exp=%b", i, c0, exp_ctrl(s0[i], OP_RES)); end
            total++; if (retired0 !== 4'd0) begin bad++; $display("FAIL res_halt_retired i=%0d got=%0d exp=0", i, retired0); end
            total++; if (state1 !== 3'(s1[i])) begin bad++; $display("FAIL res_nop_state i=%0d got=%0d exp=%0d", i, state1, s1[i]); end
            total++; if (c1 !== exp_ctrl(s1[i], OP_RES)) begin bad++; $display("FAIL res_nop_ctrl i=%0d got=%b exp=%b", i, c1, exp_ctrl(s1[i], OP_RES)); end
            enable = (i < 4);
        end
        total++; if (retired1 !== 16'd1 || halted1 !== 1'b0) begin bad++; $display("FAIL res_nop_retired got=%0d halted=%b exp=1/0", retired1, halted1); end
    endtask

    task automatic test_enable_drop;
        int seq[7] = '{0, 1, 2, 3, 5, 0, 0};
        do_reset();
        opcode = OP_SEL; rom_ready = 1'b1; ram_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            total++; if (state0 !== 3'(seq[i])) begin bad++; $display("FAIL drop_state i=%0d got=%0d exp=%0d", i, state0, seq[i]); end
            total++; if (c0 !== exp_ctrl(seq[i], OP_SEL)) begin bad++; $display("FAIL drop_ctrl i=%0d got=%b exp=%b", i, c0, exp_ctrl(seq[i], OP_SEL)); end
            enable = (i < 3);
        end
    endtask

    task automatic test_random;
        cyc_t q[$];
        cyc_t c;
        logic [3:0] op;
        int wr, wm, ret;
        bit mem;
        localparam int N = 24;
        do_reset();
        c = '{ST_IDLE, 7'd0, 1'b0, 1'b0, 4'd0, 1'b1};
        q.push_back(c);
        for (int k = 0; k < N; k++) begin
            do op = 4'($urandom_range(0, 15)); while (op == OP_RES);
            mem = (op == OP_LOD) || (op == OP_STR);
            wr  = $urandom_range(0, 3);
            wm  = mem ? $urandom_range(0, 4) : 0;
            for (int i = 0; i <= wr; i++) begin
                c = '{ST_FETCH, exp_ctrl(ST_FETCH, op), i == wr, 1'($urandom),
                      (i == wr) ? op : 4'($urandom), 1'b1};
                q.push_back(c);
            end
            c = '{ST_DECODE, exp_ctrl(ST_DECODE, op), 1'($urandom), 1'($urandom), 4'($urandom), 1'b1};
            q.push_back(c);
            c = '{ST_EXECUTE, exp_ctrl(ST_EXECUTE, op), 1'($urandom),
                  mem ? (wm == 0) : 1'($urandom), 4'($urandom), 1'b1};
            q.push_back(c);
            for (int i = 0; i < wm; i++) begin
                c = '{ST_MEMWAIT, exp_ctrl(ST_MEMWAIT, op), 1'($urandom), i == wm - 1, 4'($urandom), 1'b1};
                q.push_back(c);
            end
            c = '{ST_STORE, exp_ctrl(ST_STORE, op), 1'($urandom), 1'($urandom), 4'($urandom), k != N - 1};
            q.push_back(c);
        end
        c = '{ST_IDLE, 7'd0, 1'b0, 1'b0, 4'd0, 1'b0};
        q.push_back(c);
        ret = 0;
        foreach (q[i]) begin
            @(negedge clock);
            total++; if (state0 !== 3'(q[i].st)) begin bad++; $display("FAIL rnd_state0 cyc=%0d got=%0d exp=%0d", i, state0, q[i].st); end
            total++; if (state1 !== 3'(q[i].st)) begin bad++; $display("FAIL rnd_state1 cyc=%0d got=%0d exp=%0d", i, state1, q[i].st); end
            total++; if (c0 !== q[i].ctrl) begin bad++; $display("FAIL rnd_ctrl0 cyc=%0d got=%b exp=%b", i, c0, q[i].ctrl); end
            total++; if (c1 !== q[i].ctrl) begin bad++; $display("FAIL rnd_ctrl1 cyc=%0d got=%b exp=%b", i, c1, q[i].ctrl); end
            total++; if (retired0 !== 4'(ret)) begin bad++; $display("FAIL rnd_retired0 cyc=%0d got=%0d exp=%0d", i, retired0, ret % 16); end
            total++; if (retired1 !== 16'(ret)) begin bad++; $display("FAIL rnd_retired1 cyc=%0d got=%0d exp=%0d", i, retired1, ret); end
            enable    = q[i].en;
            rom_ready = q[i].rom;
            ram_ready = q[i].ram;
            opcode    = q[i].op;
            if (q[i].st == ST_STORE) ret++;
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_step;
        int s1[8]  = '{0, 0, 1, 2, 3, 5, 0, 0};
        int s2[12] = '{0, 0, 1, 2, 6, 6, 6, 1, 2, 3, 5, 0};
        do_reset();
        step = 1'b0; opcode = OP_JMP; rom_ready = 1'b1; ram_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            total++; if (state0 !== 3'(s1[i])) begin bad++; $display("FAIL step_state i=%0d got=%0d exp=%0d", i, state0, s1[i]); end
            total++; if (c0 !== exp_ctrl(s1[i], OP_JMP)) begin bad++; $display("FAIL step_ctrl i=%0d got=%b exp=%b", i, c0, exp_ctrl(s1[i], OP_JMP)); end
            step = (i >= 1 && i <= 4);
        end
        do_reset();
        step = 1'b0; opcode = OP_RES; rom_ready = 1'b1; ram_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            total++; if (state0 !== 3'(s2[i])) begin bad++; $display("FAIL step_halt_state i=%0d got=%0d exp=%0d", i, state0, s2[i]); end
            total++; if (halted0 !== (s2[i] == ST_HALT)) begin bad++; $display("FAIL step_halted i=%0d got=%b exp=%b", i, halted0, s2[i] == ST_HALT); end
            step = (i == 1) || (i == 6);
            if (i == 6) opcode = OP_ADD;
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        test_reset();
        test_add();
        test_lod_wait();
        test_timeout();
        test_res();
        test_enable_drop();
        test_random();
`ifdef SINGLE_STEP_EN
        test_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/nbbpu_sequencer.md
Name: nbbpu_sequencer

Overview:
Parametrised successor to the NBBPU control decoder. It owns the instruction-cycle state machine rather than receiving state from outside. It adds ready handshakes to ROM and RAM, wait-state timeout, halt, run/idle control and a retired-instruction counter. It sits between the program counter/ROM/RAM interfaces and the register file/ALU, driving the same seven control strobes.

Parameters:
WAIT_LIMIT, 16, consecutive wait cycles (FETCH or MEMWAIT) before FAULT; 0 disables the timeout
RETIRE_WIDTH, 16, width of retired-instruction counter
HALT_ON_RES, 1, 1: opcode RES (4'b1011) halts the core; 0: RES is a no-op

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  run request; sampled in IDLE and STORE
opcode  in  4  instruction opcode from ROM, valid when rom_ready=1
rom_ready  in  1  ROM has instruction available
ram_ready  in  1  RAM completed the current read/write
instruction_enable  out  1  ROM fetch strobe
read_enable  out  1  RAM read
reg_write  out  1  register file write
reg_set  out  1  register set (SEL/SEU)
write_enable  out  1  RAM write
jump_PC  out  1  PC jump
branch_PC  out  1  PC branch
state  out  3  current FSM state (encoding below)
halted  out  1  core in HALT
fault  out  1  core in FAULT
retired  out  RETIRE_WIDTH  retired instruction count

Behaviour:
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMWAIT=4, STORE=5, HALT=6, FAULT=7.
- Reset (reset=0, async): state=IDLE, opcode_q=0, wait_count=0, retired=0. All control outputs, halted and fault are 0.
- IDLE: enable=1 -> FETCH, otherwise stay.
- FETCH: instruction_enable=1. While rom_ready=0, stay and increment wait_count. On rom_ready=1, latch opcode into opcode_q, clear wait_count, go to DECODE.
- DECODE: if opcode_q=RES and HALT_ON_RES=1 -> HALT; otherwise -> EXECUTE.
- EXECUTE: if opcode_q is LOD or STR and ram_ready=0 -> MEMWAIT; otherwise -> STORE.
- MEMWAIT: controls are held equal to the EXECUTE controls and wait_count increments. On ram_ready=1, clear wait_count and go to STORE.
- STORE: retired increments by 1, wrapping modulo 2^RETIRE_WIDTH. Then enable=1 -> FETCH, enable=0 -> IDLE.
- Deasserting enable mid-instruction: the instruction completes and the FSM stops at IDLE after STORE.
- Timeout: with WAIT_LIMIT>0, if wait_count reaches WAIT_LIMIT while waiting, go to FAULT on that edge. A ready arriving in that same cycle takes precedence, so no fault occurs.
- FAULT: fault=1, all controls 0, no exit except reset.
- HALT: halted=1, all controls 0, no exit except reset or step (see Optional Feature).
- Controls are combinational from (state, opcode_q), never from the live opcode input. Any control not listed below is 0.
- DECODE controls: JMP -> jump_PC; BRZ/BRN -> branch_PC.
- EXECUTE/MEMWAIT controls: JMP -> jump_PC; BRZ/BRN -> branch_PC; LOD -> read_enable; STR -> write_enable; SEL/SEU -> reg_set.
- STORE controls:
  - ADD..CMP (0-7) -> reg_write
  - JMP -> reg_write + jump_PC
  - BRZ/BRN -> branch_PC
  - LOD -> read_enable + reg_write
  - STR -> write_enable
  - SEL/SEU -> reg_set + reg_write
  - RES (HALT_ON_RES=0) -> none
- halted and fault are registered with the state; retired is registered.

Optional Feature:
SINGLE_STEP_EN.
- Defined: adds input port step (1 bit). In IDLE with enable=0, a rising edge of step (edge-detected internally, registered) runs exactly one instruction and returns to IDLE after STORE. In HALT, a step rising edge resumes at FETCH for one instruction. Step is ignored in all other states.
- Undefined: no step port and no edge detector. HALT exits only via reset.

Test Plan:
- ADD, rom_ready=1, ram_ready=1, enable=1 -> state sequence 1,2,3,5,1. reg_write=1 only in STORE. retired goes 0->1.
- LOD with ram_ready held 0 for 3 cycles -> EXECUTE then MEMWAIT x3 with read_enable=1, then STORE with read_enable=reg_write=1.
- FETCH with rom_ready=0, WAIT_LIMIT=4 -> fault=1 and state=7 after 4 waits, all controls 0. Assert reset=0 -> IDLE.
- RES with HALT_ON_RES=1 -> HALT (state=6, halted=1), retired unchanged. Same opcode with HALT_ON_RES=0 -> STORE, no strobes, retired+1.
- enable dropped during EXECUTE of SEL -> STORE drives reg_set=reg_write=1, then IDLE. Separately, RETIRE_WIDTH=4 after 16 instructions -> retired=0.
- SINGLE_STEP_EN defined: enable=0, one step pulse with JMP -> exactly one instruction, jump_PC high in DECODE/EXECUTE/STORE, return to IDLE.
